// File: rtl/id_issue_queue.sv
// ID->issue decoupling FIFO of DEPTH entries with a cap of MAX_CF control-flow entries.
// Define ID_ISSUE_QUEUE_BYPASS_EN for a zero-latency pass-through while the queue is empty.
module id_issue_queue #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_CF     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DATA_WIDTH-1:0]        in_data_i,
  input  logic                         in_is_cf_i,
  output logic                         out_valid_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic                         out_is_cf_o,
  input  logic                         out_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o,
  output logic [$clog2(MAX_CF+1)-1:0]  cf_count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned USE_W = $clog2(DEPTH + 1);
  localparam int unsigned CF_W  = $clog2(MAX_CF + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [USE_W-1:0] DEPTH_U  = USE_W'(DEPTH);
  localparam logic [CF_W-1:0]  MAX_CF_U = CF_W'(MAX_CF);

  logic [DATA_WIDTH-1:0] dataMem_q [DEPTH];
  logic [DEPTH-1:0]      cfMem_q;

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [USE_W-1:0] usage_q, usage_d;
  logic [CF_W-1:0]  cfCount_q, cfCount_d;

  logic empty;
  logic push;
  logic pop;
  logic cfOk;

  assign empty = (usage_q == '0);

  always_comb begin
    out_valid_o = !empty;
    out_data_o  = dataMem_q[rdPtr_q];
    out_is_cf_o = cfMem_q[rdPtr_q];
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
    // Empty queue forwards the decoder entry; push+pop then cancel in the counters.
    if (empty && !flush_i) begin
      out_valid_o = in_valid_i;
      out_data_o  = in_data_i;
      out_is_cf_o = in_is_cf_i;
    end
`endif
  end

  assign pop        = out_ack_i & out_valid_o;
  assign cfOk       = !in_is_cf_i | (cfCount_q < MAX_CF_U) | (pop & out_is_cf_o);
  assign in_ready_o = !flush_i & rst_ni & ((usage_q < DEPTH_U) | pop) & cfOk;
  assign push       = in_valid_i & in_ready_o;

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    usage_d   = usage_q + USE_W'(push) - USE_W'(pop);
    cfCount_d = cfCount_q + CF_W'(push & in_is_cf_i) - CF_W'(pop & out_is_cf_o);
    if (push) begin
      wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PTR_W'(1);
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PTR_W'(1);
    end
    if (flush_i) begin
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      usage_d   = '0;
      cfCount_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      usage_q   <= '0;
      cfCount_q <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      usage_q   <= usage_d;
      cfCount_q <= cfCount_d;
    end
  end

  // Payload storage is deliberately left without reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      dataMem_q[wrPtr_q] <= in_data_i;
      cfMem_q[wrPtr_q]   <= in_is_cf_i;
    end
  end

  assign usage_o    = usage_q;
  assign cf_count_o = cfCount_q;

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue: a DEPTH=4 instance and a DEPTH=3 instance share one stimulus stream.
module tb_id_issue_queue;

  logic        clk = 1'b0;
  logic        rstN;
  logic        flush;
  logic        inValid;
  logic [63:0] inData;
  logic        inIsCf;
  logic        outAck;

  logic        inReadyA, outValidA, outIsCfA;
  logic [63:0] outDataA;
  logic [2:0]  usageA;
  logic [1:0]  cfCountA;

  logic        inReadyB, outValidB, outIsCfB;
  logic [63:0] outDataB;
  logic [1:0]  usageB;
  logic [1:0]  cfCountB;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_issue_queue #(.DATA_WIDTH(64), .DEPTH(4), .MAX_CF(2)) dut (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flush),
    .in_valid_i(inValid), .in_ready_o(inReadyA), .in_data_i(inData), .in_is_cf_i(inIsCf),
    .out_valid_o(outValidA), .out_data_o(outDataA), .out_is_cf_o(outIsCfA), .out_ack_i(outAck),
    .usage_o(usageA), .cf_count_o(cfCountA)
  );

  id_issue_queue #(.DATA_WIDTH(64), .DEPTH(3), .MAX_CF(2)) dut3 (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flush),
    .in_valid_i(inValid), .in_ready_o(inReadyB), .in_data_i(inData), .in_is_cf_i(inIsCf),
    .out_valid_o(outValidB), .out_data_o(outDataB), .out_is_cf_o(outIsCfB), .out_ack_i(outAck),
    .usage_o(usageB), .cf_count_o(cfCountB)
  );

  // Inputs change on the falling edge; checks run 1 time unit later, well clear of the rising edge.
  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic cf,
                               input logic ack, input logic fl);
    @(negedge clk);
    inValid = v;
    inData  = d;
    inIsCf  = cf;
    outAck  = ack;
    flush   = fl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  initial begin
    rstN    = 1'b0;
    flush   = 1'b0;
    inValid = 1'b1;
    inData  = 64'hBAD;
    inIsCf  = 1'b0;
    outAck  = 1'b0;

    // Reset held two edges with a valid entry presented.
    applyStimulus(1'b1, 64'hBAD, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_ready_0", inReadyA, 0);
    applyStimulus(1'b1, 64'hBAD, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_ready_1", inReadyA, 0);
    checkOutput("rst_usage", usageA, 0);
    inValid = 1'b0;
    rstN    = 1'b1;
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_usage", usageA, 0);
    checkOutput("post_rst_valid", outValidA, 0);
    checkOutput("post_rst_ready", inReadyA, 1);
    checkOutput("post_rst_cf", cfCountA, 0);
    checkOutput("post_rst_usage3", usageB, 0);

    // Fill to DEPTH, then drain in order.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 64'h100 + 64'(k), 1'b0, 1'b0, 1'b0);
      checkOutput("fill_ready", inReadyA, 1);
    end
    applyStimulus(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b0);
    checkOutput("full_usage", usageA, 4);
    checkOutput("full_ready", inReadyA, 0);
    checkOutput("full_head", outDataA, 64'h100);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("drain_valid", outValidA, 1);
      checkOutput("drain_data", outDataA, 64'h100 + 64'(k));
    end
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("drained_usage", usageA, 0);
    checkOutput("drained_valid", outValidA, 0);

    // Ack while empty must be ignored.
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("ack_empty_usage", usageA, 0);

    // Full queue accepts a push in the same cycle as a pop.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 64'h200 + 64'(k), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 64'h2E, 1'b0, 1'b1, 1'b0);
    checkOutput("fullack_ready", inReadyA, 1);
    checkOutput("fullack_head", outDataA, 64'h200);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
      if (k == 1) checkOutput("fullack_usage", usageA, 4);
      checkOutput("fullack_drain", outDataA, (k < 4) ? 64'h200 + 64'(k) : 64'h2E);
    end
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("fullack_empty", usageA, 0);

    // Control-flow cap.
    applyStimulus(1'b1, 64'h301, 1'b1, 1'b0, 1'b0);
    checkOutput("cf1_ready", inReadyA, 1);
    applyStimulus(1'b1, 64'h302, 1'b1, 1'b0, 1'b0);
    checkOutput("cf2_ready", inReadyA, 1);
    applyStimulus(1'b1, 64'h303, 1'b1, 1'b0, 1'b0);
    checkOutput("cf_count_full", cfCountA, 2);
    checkOutput("cf3_blocked", inReadyA, 0);
    applyStimulus(1'b1, 64'h3A0, 1'b0, 1'b0, 1'b0);
    checkOutput("noncf_ready", inReadyA, 1);
    applyStimulus(1'b1, 64'h303, 1'b1, 1'b1, 1'b0);
    checkOutput("cf_swap_ready", inReadyA, 1);
    checkOutput("cf_swap_head_cf", outIsCfA, 1);
    checkOutput("cf_swap_head", outDataA, 64'h301);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("cf_after_count", cfCountA, 2);
    checkOutput("cf_after_usage", usageA, 3);
    checkOutput("cf_after_head", outDataA, 64'h302);

    // Flush with push and ack requested in the same cycle.
    applyStimulus(1'b1, 64'h3FF, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_ready", inReadyA, 0);
    checkOutput("flush_usage_before", usageA, 3);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_usage", usageA, 0);
    checkOutput("flush_cf", cfCountA, 0);
    checkOutput("flush_valid", outValidA, 0);

    // Push with ack into an empty queue.
    applyStimulus(1'b1, 64'h5, 1'b0, 1'b1, 1'b0);
    checkOutput("empty_ack_ready", inReadyA, 1);
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
    checkOutput("bypass_valid", outValidA, 1);
    checkOutput("bypass_data", outDataA, 64'h5);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("bypass_not_stored", outValidA, 0);
    checkOutput("bypass_usage", usageA, 0);
`else
    checkOutput("nobypass_valid", outValidA, 0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("latency_valid", outValidA, 1);
    checkOutput("latency_data", outDataA, 64'h5);
    checkOutput("latency_usage", usageA, 1);
`endif
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_wrap_usage", usageA, 0);
    checkOutput("pre_wrap_usage3", usageB, 0);

    // Interleaved push/pop wrapping both pointer sets several times.
    for (int s = 0; s < 10; s++) begin
      applyStimulus(1'b1, 64'(s + 1), 1'b0, (s >= 2), 1'b0);
      checkOutput("wrap_ready3", inReadyB, 1);
      if (s >= 2) begin
        checkOutput("wrap_data3", outDataB, 64'(s - 1));
        checkOutput("wrap_data", outDataA, 64'(s - 1));
        checkOutput("wrap_usage3", usageB, 2);
      end
    end
    for (int s = 10; s < 12; s++) begin
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("wrap_tail3", outDataB, 64'(s - 1));
      checkOutput("wrap_tail", outDataA, 64'(s - 1));
    end
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap_end_usage3", usageB, 0);
    checkOutput("wrap_end_valid3", outValidB, 0);
    checkOutput("wrap_end_usage", usageA, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
